serial_digit_adder: RTL and testbench
=====================================

// Module: serial_digit_adder
// PURPOSE
//  Multi-cycle adder, parametrised successor to the single-bit half adder.
//  Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, with a carry register between digits.
//  Valid/ready handshake on the operand and result sides. Sits behind the TT user wrapper, fed from ui_in/uio_in.
// PARAMETERS
//  WIDTH  8  operand/sum width; must be a multiple of DIGIT (elaboration error otherwise)
//  DIGIT  1  bits processed per cycle; N = WIDTH/DIGIT cycles per operation
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, synchronous, active-high
//  in_valid   in   1      operands a/b/cin valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A (unsigned or two's complement)
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (borrow-in when subtracting)
//  sub        in   1      1 = subtract; present only with SERADD_SUB_EN
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry-out (no-borrow flag when subtracting)
//  ovf        out  1      signed overflow
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1; out_valid=0; sum=0; cout=0; ovf=0; count and carry cleared.
//  - FSM IDLE -> RUN -> DONE -> IDLE. in_ready = (state==IDLE); out_valid = (state==DONE).
//  - IDLE: on in_valid&&in_ready, capture a, b (or ~b), carry0, and the operand MSBs; count=0; go RUN.
//  - RUN: each cycle, add the low DIGIT bits of the A/B shift registers plus the carry register.
//    Shift the digit sum into sum from the MSB end; shift A/B right by DIGIT; update carry; count++.
//    After the edge where count reaches N-1, go DONE.
//  - Latency: out_valid rises exactly N edges after the acceptance edge (WIDTH=8, DIGIT=1: 8; DIGIT=4: 2).
//  - DONE: sum/cout/ovf held stable until out_valid&&out_ready; on that edge go IDLE.
//    Outputs keep their values in IDLE until the next result. Minimum throughput: one op per N+2 cycles.
//  - in_valid while busy (RUN/DONE) is ignored; a/b/cin sampled only on the acceptance edge.
//  - Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
//    ovf = (A_msb == B'_msb) && (sum[WIDTH-1] != A_msb), where B' is the operand actually added.
//  - Wrap: 0xFF+0x01 gives sum=0x00, cout=1. cin=1 with a=b=all-ones gives sum=all-ones, cout=1.
//  - rst asserted in any state, including mid-RUN: the next edge gives reset values and the operation is discarded.
//    No partial result is ever presented.
//  - rst and in_valid in the same cycle: reset wins; no capture.
// CONFIGURATION
//  - SERADD_SUB_EN defined: sub port exists, sampled with the operands.
//    When sub=1: B' = ~b, carry0 = ~cin; sum = a - b - cin mod 2^WIDTH; cout = 1 iff no borrow (a >= b+cin unsigned).
//    When sub=0: add as above.
//  - SERADD_SUB_EN undefined: no sub port; B' = b, carry0 = cin; add only.
// STRUCTURE
//  - Package serial_digit_adder_pkg: state enum (IDLE, RUN, DONE) as 2-bit typedef; count width function clog2(N).
//  - Sub-module add_digit: combinational DIGIT-bit ripple slice {co,s} = x + y + ci. One instance, reused each cycle.
// TESTING (WIDTH=8, DIGIT=1 unless stated; out_ready=1 unless stated)
//  - 0x0F+0x01, cin=0 -> after 8 cycles out_valid=1, sum=0x10, cout=0, ovf=0.
//  - 0xFF+0x01 -> sum=0x00, cout=1, ovf=0. 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
//  - Backpressure: out_ready=0 for 5 cycles in DONE -> sum held, in_ready=0, in_valid pulses ignored.
//    Raise out_ready -> IDLE next edge.
//  - rst pulse at RUN cycle 3 -> next cycle out_valid=0, in_ready=1, sum=0. A new op 0x03+0x04 then gives 0x07.
//  - DIGIT=4: 0xA5+0x5B, cin=1 -> out_valid after 2 cycles, sum=0x01, cout=1.
//  - SERADD_SUB_EN, sub=1: 0x05-0x07, cin=0 -> sum=0xFE, cout=0. 0x07-0x05 -> sum=0x02, cout=1.

Source files
------------

// File: rtl/serial_digit_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package serial_digit_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // A one-digit operation still needs a 1-bit counter.
    function automatic int count_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/serial_digit_adder_add_digit.sv
// Combinational DIGIT-bit slice: {co, s} = x + y + ci.
module add_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + (DIGIT+1)'(ci);

endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial adder, DIGIT bits per clock, valid/ready on both sides.
// Optional subtract mode (sub port) is enabled by defining SERADD_SUB_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1, last result held
// RUN   | one digit added per cycle, carry kept between digits
// DONE  | result presented until out_ready
module serial_digit_adder
    import serial_digit_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = count_width(N);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("serial_digit_adder: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_next;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q, cout_q, ovf_q;
    logic             a_msb_q, b_msb_q;
    logic             sub_en;
    logic [WIDTH-1:0] b_eff;
    logic             carry0;
    logic [DIGIT-1:0] dsum;
    logic             dcarry;
    logic             accept, last;

`ifdef SERADD_SUB_EN
    assign sub_en = sub;
`else
    assign sub_en = 1'b0;
`endif

    // Subtraction is a + ~b + ~cin: borrow-in becomes an inverted carry-in.
    assign b_eff  = b ^ {WIDTH{sub_en}};
    assign carry0 = cin ^ sub_en;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (state_q == RUN) && (count_q == CW'(N - 1));

    add_digit #(.DIGIT(DIGIT)) u_digit (
        .x  (a_q[DIGIT-1:0]),
        .y  (b_q[DIGIT-1:0]),
        .ci (carry_q),
        .s  (dsum),
        .co (dcarry)
    );

    assign acc_next = (acc_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Partial sums build in acc_q; sum only updates once the last digit lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            count_q <= '0;
            a_q     <= a;
            b_q     <= b_eff;
            acc_q   <= '0;
            carry_q <= carry0;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b_eff[WIDTH-1];
        end else if (state_q == RUN) begin
            count_q <= count_q + CW'(1);
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            acc_q   <= acc_next;
            carry_q <= dcarry;
            if (last) begin
                sum_q  <= acc_next;
                cout_q <= dcarry;
                ovf_q  <= (a_msb_q == b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed bench for serial_digit_adder: DIGIT=1 and DIGIT=4 instances, WIDTH=8.
module tb_serial_digit_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, sum;
    logic       cin, cout, ovf;
    logic       sub;
    logic       in_valid4, in_ready4, out_valid4, cout4, ovf4;
    logic [7:0] sum4;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    serial_digit_adder #(.WIDTH(8), .DIGIT(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef SERADD_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_digit_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a), .b(b), .cin(cin),
`ifdef SERADD_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid4), .out_ready(out_ready),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    // Launch one op on the DIGIT=1 instance and count edges until out_valid (bounded).
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
        a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (sum !== 8'h00)      begin fails++; $display("FAIL reset_sum got=%h exp=00", sum); end
        tests++; if (cout !== 1'b0 || ovf !== 1'b0) begin fails++; $display("FAIL reset_flags got cout=%b ovf=%b exp 0 0", cout, ovf); end
        tests++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || sum4 !== 8'h00) begin
            fails++; $display("FAIL reset_dut4 got in_ready=%b out_valid=%b sum=%h exp 1 0 00", in_ready4, out_valid4, sum4);
        end
    endtask

    task automatic test_add();
        logic [7:0] va[7]   = '{8'h0F, 8'hFF, 8'h7F, 8'hFF, 8'h80, 8'hA5, 8'h3C};
        logic [7:0] vb[7]   = '{8'h01, 8'h01, 8'h01, 8'hFF, 8'h80, 8'h5B, 8'h35};
        logic       vc[7]   = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
        logic [7:0] es[7]   = '{8'h10, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h01, 8'h72};
        logic       eco[7]  = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
        logic       eov[7]  = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], vc[i], lat);
            tests++; if (lat !== 8) begin fails++; $display("FAIL add%0d_latency got=%0d exp=8", i, lat); end
            tests++; if (sum !== es[i]) begin fails++; $display("FAIL add%0d_sum got=%h exp=%h", i, sum, es[i]); end
            tests++; if (cout !== eco[i] || ovf !== eov[i]) begin
                fails++; $display("FAIL add%0d_flags got cout=%b ovf=%b exp cout=%b ovf=%b", i, cout, ovf, eco[i], eov[i]);
            end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL add%0d_busy got in_ready=%b exp=0", i, in_ready); end
            @(posedge clk); #1;
            tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== es[i]) begin
                fails++; $display("FAIL add%0d_release got out_valid=%b in_ready=%b sum=%h exp 0 1 %h", i, out_valid, in_ready, sum, es[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        out_ready = 1'b0;
        run_op(8'h12, 8'h34, 1'b0, lat);
        tests++; if (lat !== 8 || sum !== 8'h46) begin fails++; $display("FAIL bp_result got lat=%0d sum=%h exp 8 46", lat, sum); end
        bad = 0;
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 8'h46 || cout !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL bp_hold got %0d bad cycles exp 0 (sum=%h)", bad, sum); end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 8'h46) begin
            fails++; $display("FAIL bp_release got out_valid=%b in_ready=%b sum=%h exp 0 1 46", out_valid, in_ready, sum);
        end
        bad = 0;
        repeat (10) begin @(posedge clk); #1; if (out_valid !== 1'b0) bad++; end
        tests++; if (bad != 0) begin fails++; $display("FAIL bp_no_capture got %0d valid cycles exp 0", bad); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int bad;
        out_ready = 1'b1;
        a = 8'h55; b = 8'h11; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 8'h00 || cout !== 1'b0) begin
            fails++; $display("FAIL midrst_state got out_valid=%b in_ready=%b sum=%h cout=%b exp 0 1 00 0", out_valid, in_ready, sum, cout);
        end
        bad = 0;
        repeat (10) begin @(posedge clk); #1; if (out_valid !== 1'b0) bad++; end
        tests++; if (bad != 0) begin fails++; $display("FAIL midrst_no_partial got %0d valid cycles exp 0", bad); end
        run_op(8'h03, 8'h04, 1'b0, lat);
        tests++; if (lat !== 8 || sum !== 8'h07 || cout !== 1'b0) begin
            fails++; $display("FAIL midrst_next_op got lat=%0d sum=%h cout=%b exp 8 07 0", lat, sum, cout);
        end
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1; a = 8'h20; b = 8'h22;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        tests++; if (in_ready !== 1'b1 || sum !== 8'h00) begin
            fails++; $display("FAIL rst_vs_valid got in_ready=%b sum=%h exp 1 00", in_ready, sum);
        end
        bad = 0;
        repeat (10) begin @(posedge clk); #1; if (out_valid !== 1'b0) bad++; end
        tests++; if (bad != 0) begin fails++; $display("FAIL rst_vs_valid_capture got %0d valid cycles exp 0", bad); end
    endtask

    task automatic test_digit4();
        logic [7:0] va[2] = '{8'hA5, 8'h7F};
        logic [7:0] vb[2] = '{8'h5B, 8'h01};
        logic       vc[2] = '{1'b1,  1'b0};
        logic [7:0] es[2] = '{8'h01, 8'h80};
        logic       eco[2] = '{1'b1, 1'b0};
        logic       eov[2] = '{1'b0, 1'b1};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a = va[i]; b = vb[i]; cin = vc[i]; in_valid4 = 1'b1;
            @(posedge clk); #1;
            in_valid4 = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
            lat = 0;
            while (!out_valid4 && lat < 20) begin @(posedge clk); #1; lat++; end
            tests++; if (lat !== 2) begin fails++; $display("FAIL d4_%0d_latency got=%0d exp=2", i, lat); end
            tests++; if (sum4 !== es[i] || cout4 !== eco[i] || ovf4 !== eov[i]) begin
                fails++; $display("FAIL d4_%0d_result got sum=%h cout=%b ovf=%b exp %h %b %b", i, sum4, cout4, ovf4, es[i], eco[i], eov[i]);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef SERADD_SUB_EN
    task automatic test_sub();
        logic [7:0] va[3] = '{8'h05, 8'h07, 8'h80};
        logic [7:0] vb[3] = '{8'h07, 8'h05, 8'h01};
        logic [7:0] es[3] = '{8'hFE, 8'h02, 8'h7F};
        logic       eco[3] = '{1'b0, 1'b1, 1'b1};
        logic       eov[3] = '{1'b0, 1'b0, 1'b1};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sub = 1'b1;
            run_op(va[i], vb[i], 1'b0, lat);
            sub = 1'b0;
            tests++; if (lat !== 8 || sum !== es[i] || cout !== eco[i] || ovf !== eov[i]) begin
                fails++; $display("FAIL sub%0d got lat=%0d sum=%h cout=%b ovf=%b exp 8 %h %b %b", i, lat, sum, cout, ovf, es[i], eco[i], eov[i]);
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_backpressure();
        test_reset_mid_run();
        test_digit4();
`ifdef SERADD_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
